// File: rtl/reg_file_operand.sv
// LC-3 general-purpose register file with N/Z/P condition codes and the SR2MUX
// operand-select stage that feeds the ALU 'a' and 'b' inputs.
module reg_file_operand #(
    parameter int WIDTH     = 16,
    parameter int NREGS     = 8,
    parameter int IMM_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ld_reg,
    input  logic [$clog2(NREGS)-1:0]   dr,
    input  logic [WIDTH-1:0]           bus,
    input  logic                       ld_cc,
    input  logic [$clog2(NREGS)-1:0]   sr1,
    input  logic [$clog2(NREGS)-1:0]   sr2,
    input  logic [IMM_WIDTH-1:0]       imm5,
    input  logic                       sr2mux_sel,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic                       n,
    output logic                       z,
    output logic                       p
);

    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] regs_r [NREGS];
    logic             n_r;
    logic             z_r;
    logic             p_r;
    logic [WIDTH-1:0] sext_imm_s;
    logic [WIDTH-1:0] alu_a_s;
    logic [WIDTH-1:0] alu_b_s;
    logic             dr_ok_s;
    logic             sr1_ok_s;
    logic             sr2_ok_s;

    // Indices beyond NREGS only exist when NREGS is not a power of two.
    function automatic logic idx_valid(input logic [AW-1:0] idx);
        return (int'(idx) < NREGS);
    endfunction

    assign sext_imm_s = {{(WIDTH-IMM_WIDTH){imm5[IMM_WIDTH-1]}}, imm5};

    // Index range decode for the write port and both read ports.
    always_comb begin
        dr_ok_s  = idx_valid(dr);
        sr1_ok_s = idx_valid(sr1);
        sr2_ok_s = idx_valid(sr2);
    end

    // Register array: reset clears all, otherwise single writeback per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (ld_reg && dr_ok_s) begin
            regs_r[dr] <= bus;
        end
    end

    // Condition codes: exactly one of N/Z/P is set from reset onward.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_r <= 1'b0;
            z_r <= 1'b1;
            p_r <= 1'b0;
        end else if (ld_cc) begin
            n_r <= bus[WIDTH-1];
            z_r <= (bus == {WIDTH{1'b0}});
            p_r <= !bus[WIDTH-1] && (bus != {WIDTH{1'b0}});
        end
    end

    // Operand read and SR2MUX; no write bypass, so same-cycle reads see old data.
    always_comb begin
        alu_a_s = {WIDTH{1'b0}};
        alu_b_s = {WIDTH{1'b0}};
        if (sr1_ok_s) begin
            alu_a_s = regs_r[sr1];
        end else begin
            alu_a_s = {WIDTH{1'b0}};
        end
        if (sr2mux_sel) begin
            alu_b_s = sext_imm_s;
        end else if (sr2_ok_s) begin
            alu_b_s = regs_r[sr2];
        end else begin
            alu_b_s = {WIDTH{1'b0}};
        end
    end

    assign alu_a = alu_a_s;
    assign alu_b = alu_b_s;
    assign n     = n_r;
    assign z     = z_r;
    assign p     = p_r;

endmodule

// File: tb/tb_reg_file_operand.sv
// Self-checking bench for reg_file_operand: directed scenarios plus a randomized
// run checked against an array-based model of the register file and flags.
module tb_reg_file_operand;

    logic        clk;
    logic        reset;
    logic        ld_reg;
    logic [2:0]  dr;
    logic [15:0] bus;
    logic        ld_cc;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [4:0]  imm5;
    logic        sr2mux_sel;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        n;
    logic        z;
    logic        p;

    int checks = 0;
    int fails  = 0;

    logic [15:0] model_regs [8];
    logic [2:0]  model_nzp;

    reg_file_operand dut (
        .clk(clk), .reset(reset), .ld_reg(ld_reg), .dr(dr), .bus(bus),
        .ld_cc(ld_cc), .sr1(sr1), .sr2(sr2), .imm5(imm5),
        .sr2mux_sel(sr2mux_sel), .alu_a(alu_a), .alu_b(alu_b),
        .n(n), .z(z), .p(p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sext5(input logic [4:0] v);
        int s;
        s = int'(v);
        if (s >= 16) s = s - 32;
        return 16'(s);
    endfunction

    function automatic logic [2:0] flags_of(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        return {s < 0, s == 0, s > 0};
    endfunction

    task automatic idle_inputs();
        ld_reg = 1'b0; ld_cc = 1'b0; dr = 3'd0; bus = 16'h0000;
        sr1 = 3'd0; sr2 = 3'd0; imm5 = 5'd0; sr2mux_sel = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
        model_nzp = 3'b010;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                sr1 = 3'(a); sr2 = 3'(b);
                #1;
                checks++;
                if (alu_a !== 16'h0000 || alu_b !== 16'h0000) begin
                    fails++;
                    $display("FAIL reset_read sr1=%0d sr2=%0d got a=%h b=%h exp 0000/0000", a, b, alu_a, alu_b);
                end
            end
        end
        checks++;
        if ({n, z, p} !== 3'b010) begin
            fails++;
            $display("FAIL reset_cc got %b exp 010", {n, z, p});
        end
    endtask

    task automatic test_write_read();
        ld_reg = 1'b1; dr = 3'd3; bus = 16'h1234; sr1 = 3'd3;
        #1;
        checks++;
        if (alu_a !== 16'h0000) begin
            fails++;
            $display("FAIL same_cycle_read got %h exp 0000", alu_a);
        end
        tick();
        model_regs[3] = 16'h1234;
        ld_reg = 1'b0;
        #1;
        checks++;
        if (alu_a !== 16'h1234) begin
            fails++;
            $display("FAIL next_cycle_read got %h exp 1234", alu_a);
        end
    endtask

    task automatic test_operand_select();
        sr2mux_sel = 1'b1; imm5 = 5'b10000; sr2 = 3'd3;
        #1;
        checks++;
        if (alu_b !== 16'hFFF0) begin
            fails++;
            $display("FAIL sext_neg got %h exp fff0", alu_b);
        end
        imm5 = 5'b01111;
        #1;
        checks++;
        if (alu_b !== 16'h000F) begin
            fails++;
            $display("FAIL sext_pos got %h exp 000f", alu_b);
        end
        sr2mux_sel = 1'b0;
        #1;
        checks++;
        if (alu_b !== 16'h1234) begin
            fails++;
            $display("FAIL sr2_select got %h exp 1234", alu_b);
        end
    endtask

    task automatic test_cc();
        logic [15:0] vals [3];
        logic [2:0]  exps [3];
        vals[0] = 16'h8000; exps[0] = 3'b100;
        vals[1] = 16'h0000; exps[1] = 3'b010;
        vals[2] = 16'h0001; exps[2] = 3'b001;
        for (int i = 0; i < 3; i++) begin
            ld_cc = 1'b1; bus = vals[i];
            tick();
            checks++;
            if ({n, z, p} !== exps[i]) begin
                fails++;
                $display("FAIL cc_load bus=%h got %b exp %b", vals[i], {n, z, p}, exps[i]);
            end
        end
        ld_cc = 1'b0; bus = 16'h8000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({n, z, p} !== 3'b001) begin
                fails++;
                $display("FAIL cc_hold cycle=%0d got %b exp 001", i, {n, z, p});
            end
        end
        model_nzp = 3'b001;
    endtask

    task automatic test_all_regs();
        ld_reg = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dr = 3'(i); bus = 16'(16'h1111 * i);
            tick();
            model_regs[i] = 16'(16'h1111 * i);
        end
        ld_reg = 1'b0; sr2mux_sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sr1 = 3'(i); sr2 = 3'(7 - i);
            #1;
            checks++;
            if (alu_a !== 16'(16'h1111 * i) || alu_b !== 16'(16'h1111 * (7 - i))) begin
                fails++;
                $display("FAIL sweep sr1=%0d sr2=%0d got a=%h b=%h exp %h/%h", i, 7 - i,
                         alu_a, alu_b, 16'(16'h1111 * i), 16'(16'h1111 * (7 - i)));
            end
        end
    endtask

    task automatic test_reset_override();
        ld_reg = 1'b1; dr = 3'd5; bus = 16'hBEEF; ld_cc = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0; sr1 = 3'd5;
        for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
        model_nzp = 3'b010;
        #1;
        checks++;
        if (alu_a !== 16'h0000) begin
            fails++;
            $display("FAIL reset_override_reg got %h exp 0000", alu_a);
        end
        checks++;
        if ({n, z, p} !== 3'b010) begin
            fails++;
            $display("FAIL reset_override_cc got %b exp 010", {n, z, p});
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_b;
        for (int c = 0; c < 400; c++) begin
            ld_reg = 1'($urandom_range(0, 1));
            ld_cc = 1'($urandom_range(0, 1));
            dr = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: bus = 16'h0000;
                1: bus = 16'h8000;
                default: bus = 16'($urandom);
            endcase
            sr1 = ($urandom_range(0, 1) == 1) ? dr : 3'($urandom_range(0, 7));
            sr2 = 3'($urandom_range(0, 7));
            imm5 = 5'($urandom);
            sr2mux_sel = 1'($urandom_range(0, 1));
            #1;
            exp_b = sr2mux_sel ? sext5(imm5) : model_regs[sr2];
            checks++;
            if (alu_a !== model_regs[sr1] || alu_b !== exp_b || {n, z, p} !== model_nzp) begin
                fails++;
                $display("FAIL random c=%0d got a=%h b=%h nzp=%b exp %h/%h/%b", c,
                         alu_a, alu_b, {n, z, p}, model_regs[sr1], exp_b, model_nzp);
            end
            tick();
            if (ld_reg) model_regs[dr] = bus;
            if (ld_cc) model_nzp = flags_of(bus);
        end
        idle_inputs();
        #1;
        checks++;
        if ({n, z, p} !== model_nzp) begin
            fails++;
            $display("FAIL random_final_cc got %b exp %b", {n, z, p}, model_nzp);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_operand_select();
        test_cc();
        test_all_regs();
        test_reset_override();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
